pwm_duty_sequencer: RTL
=======================

# pwm_duty_sequencer

Controller that turns debounced key levels into duty-cycle commands for the 8-bit, 256-segment PWM generator driving the LED/buzzer. Each key press applies exactly one duty action. Held keys auto-repeat after a hold delay. Simultaneous presses are arbitrated by fixed priority. The duty presented to the generator slews one LSB per PWM period, and changes only on the generator's period boundary, so no output glitch occurs mid-period.

## Interface
Parameters:
- `CLK_PER_MS`, 50000: clock cycles per 1 ms tick (50 MHz).
- `HOLD_MS`, 500: time a key must be held before auto-repeat starts.
- `REPEAT_MS`, 100: auto-repeat interval.
- `PRESET`, 127: target loaded by key 0.
- `STEP_COARSE`, 10: coarse step for keys 1/2.

Ports:
- `CLK`  in  1  system clock.
- `RSTn`  in  1  reset, asynchronous, active-low.
- `option_keys`  in  4  debounced key levels, synchronous to `CLK`, active-high. Bit 0 = preset, bit 1 = +coarse, bit 2 = -coarse, bit 3 = +1.
- `period_start`  in  1  one-cycle strobe from the PWM generator at segment counter wrap (255→0).
- `duty`  out  8  duty applied to the generator.
- `target`  out  8  commanded duty.
- `key_event`  out  1  one-cycle pulse per applied action (press or repeat).
- `busy`  out  1  high while `duty != target`.

## Operation
- **Reset values:** `duty`=0, `target`=0, `key_event`=0, `busy`=0, state=IDLE, `keys_d`=0, timers=0.
- **Edge detect:** `rise = option_keys & ~keys_d`, with `keys_d` registered every cycle.
  - Because `keys_d` resets to 0, a key held through reset release counts as a press on the first clock.
- **States and transitions:**
  - IDLE: on any `rise`, pick the highest-priority rising bit (bit0 > bit1 > bit2 > bit3), latch it as `act_key`, apply its action, and go to HOLD. Lower-priority simultaneous rises are discarded.
  - HOLD: if `act_key` is bit 0, wait here with no repeat. Otherwise, after `HOLD_MS` ms ticks, apply the action and go to REPEAT.
  - REPEAT: apply the action every `REPEAT_MS` ms ticks.
  - From HOLD or REPEAT: when `option_keys[act_key]`=0, go to IDLE with no action. This takes priority over a coinciding timer expiry.
  - Other keys pressed or released while not in IDLE are ignored. A still-held key is not re-accepted in IDLE until it is released and pressed again.
- **Timer:**
  - A cycle prescaler runs 0..`CLK_PER_MS`-1 and produces a ms tick on wrap.
  - A ms counter counts those ticks.
  - Both clear on every state entry and on every applied action.
- **Actions on `target`:** computed in 9 bits, then saturated to 0..255.
  - bit0: `target`=`PRESET`.
  - bit1: `target`=min(`target`+`STEP_COARSE`, 255).
  - bit2: `target`=max(`target`−`STEP_COARSE`, 0).
  - bit3: `target`=min(`target`+1, 255).
  - An action at saturation still pulses `key_event`.
- **Slew:** on `period_start`, `duty` moves one LSB toward `target` (+1 if `duty`<`target`, −1 if `duty`>`target`, hold if equal). `duty` never changes in any other cycle.
- **Simultaneous action and `period_start`:** the slew uses the pre-update `target`.
- **Busy:** `busy` is registered and equals (`duty != target`) after each update.

## Timing
- **Press latency:** a rising key sampled at edge k updates `target` and asserts `key_event` at edge k. Both are visible for the cycle after k. `key_event` lasts exactly 1 cycle.
- **First repeat:** occurs `HOLD_MS`×`CLK_PER_MS` cycles after the press action.
- **Subsequent repeats:** occur every `REPEAT_MS`×`CLK_PER_MS` cycles.
- **Slew rate:** `duty` reaches `target` after |`target`−`duty`| `period_start` strobes. Full scale is 255 periods (about 255 ms at a 1 ms PWM period).
- **Reset mid-operation:** asserting `RSTn` low returns all outputs to their reset values asynchronously. The in-flight action is lost.

## Test plan
Bench parameters: `CLK_PER_MS`=10, `HOLD_MS`=3, `REPEAT_MS`=2, `period_start` strobed every 20 cycles.
1. **Single press:** from reset, press bit1 for 5 cycles and release → exactly one `key_event`, `target`=10; `duty` steps 1,2,…,10 on successive `period_start` strobes; `busy` drops when `duty`=10.
2. **Auto-repeat:** hold bit3 for 100 cycles → actions at press, +30, +50, +70, +90 cycles, giving `target`=5. Release → IDLE, no further events.
3. **Priority and saturation:**
   - Assert bits 1 and 2 in the same cycle → only +10 is applied.
   - Preset with bit0 (`target`=127), then 13 taps of bit1 → `target` saturates at 255.
   - 30 taps of bit2 → `target`=0 with no wrap; `key_event` pulses every tap.
4. **Held key ignored:** hold bit2, press and release bit3 while bit2 is held → bit3 is ignored. Release bit2, then press bit3 → +1 applied.
5. **Coincident events:**
   - Key action in the same cycle as `period_start` → `duty` moves toward the old `target`.
   - Release on the exact repeat-expiry cycle → no action.
6. **Reset mid-operation:** reset mid-REPEAT with `duty`=40 → `duty`=`target`=0, `key_event`=0, `busy`=0 immediately. If the key is still held at release, one press is applied on the first clock.

Source files
------------

// File: rtl/pwm_duty_sequencer.sv
// ============================================================================
// Module      : pwm_duty_sequencer
// Description : Key-driven duty commander for an 8-bit PWM generator with
//               press/auto-repeat actions and period-aligned one-LSB slewing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_duty_sequencer #(
    parameter int CLK_PER_MS  = 50000,
    parameter int HOLD_MS     = 500,
    parameter int REPEAT_MS   = 100,
    parameter int PRESET      = 127,
    parameter int STEP_COARSE = 10
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [3:0] option_keys,
    input  logic       period_start,
    output logic [7:0] duty,
    output logic [7:0] target,
    output logic       key_event,
    output logic       busy
);

    localparam int PW     = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int MS_MAX = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
    localparam int MW     = $clog2(MS_MAX + 1);

    localparam logic [PW-1:0] C_PRESC_LAST  = PW'(CLK_PER_MS - 1);
    localparam logic [MW-1:0] C_HOLD_LAST   = MW'(HOLD_MS - 1);
    localparam logic [MW-1:0] C_REPEAT_LAST = MW'(REPEAT_MS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      act_key_q, act_key_d;
    logic [3:0]      keys_q;
    logic [PW-1:0]   presc_q, presc_d;
    logic [MW-1:0]   ms_q, ms_d;
    logic [7:0]      target_q, target_d;
    logic [7:0]      duty_q, duty_d;
    logic            key_event_q, key_event_d;
    logic            busy_q, busy_d;

    logic [3:0]      w_rise;
    logic [1:0]      w_pick;
    logic            w_tick;
    logic            w_clr;

    // Action result is formed in 9 bits so carries/borrows saturate cleanly.
    function automatic logic [7:0] f_apply(input logic [7:0] t, input logic [1:0] k);
        logic [8:0] s;
        case (k)
            2'd0:    s = 9'(PRESET);
            2'd1:    s = {1'b0, t} + 9'(STEP_COARSE);
            2'd2:    s = ({1'b0, t} < 9'(STEP_COARSE)) ? 9'd0 : ({1'b0, t} - 9'(STEP_COARSE));
            default: s = {1'b0, t} + 9'd1;
        endcase
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    assign w_rise = option_keys & ~keys_q;
    assign w_tick = (presc_q == C_PRESC_LAST);

    always_comb begin
        w_pick = 2'd3;
        if (w_rise[0])      w_pick = 2'd0;
        else if (w_rise[1]) w_pick = 2'd1;
        else if (w_rise[2]) w_pick = 2'd2;
    end

    always_comb begin
        state_d     = state_q;
        act_key_d   = act_key_q;
        target_d    = target_q;
        key_event_d = 1'b0;
        w_clr       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|w_rise) begin
                    act_key_d   = w_pick;
                    target_d    = f_apply(target_q, w_pick);
                    key_event_d = 1'b1;
                    state_d     = ST_HOLD;
                    w_clr       = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!option_keys[act_key_q]) begin
                    state_d = ST_IDLE;
                    w_clr   = 1'b1;
                end else if ((act_key_q != 2'd0) && w_tick && (ms_q == C_HOLD_LAST)) begin
                    target_d    = f_apply(target_q, act_key_q);
                    key_event_d = 1'b1;
                    state_d     = ST_REPEAT;
                    w_clr       = 1'b1;
                end
            end
            ST_REPEAT: begin
                // Release wins over a coinciding repeat expiry.
                if (!option_keys[act_key_q]) begin
                    state_d = ST_IDLE;
                    w_clr   = 1'b1;
                end else if (w_tick && (ms_q == C_REPEAT_LAST)) begin
                    target_d    = f_apply(target_q, act_key_q);
                    key_event_d = 1'b1;
                    w_clr       = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                w_clr   = 1'b1;
            end
        endcase
    end

    always_comb begin
        presc_d = presc_q;
        ms_d    = ms_q;
        if (w_clr) begin
            presc_d = '0;
            ms_d    = '0;
        end else if (w_tick) begin
            presc_d = '0;
            ms_d    = ms_q + 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    // Slew compares against the pre-update target on purpose.
    always_comb begin
        duty_d = duty_q;
        if (period_start) begin
            if (duty_q < target_q)      duty_d = duty_q + 8'd1;
            else if (duty_q > target_q) duty_d = duty_q - 8'd1;
        end
        busy_d = (duty_d != target_d);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= ST_IDLE;
            act_key_q   <= 2'd0;
            keys_q      <= 4'd0;
            presc_q     <= '0;
            ms_q        <= '0;
            target_q    <= 8'd0;
            duty_q      <= 8'd0;
            key_event_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_key_q   <= act_key_d;
            keys_q      <= option_keys;
            presc_q     <= presc_d;
            ms_q        <= ms_d;
            target_q    <= target_d;
            duty_q      <= duty_d;
            key_event_q <= key_event_d;
            busy_q      <= busy_d;
        end
    end

    assign duty      = duty_q;
    assign target    = target_q;
    assign key_event = key_event_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire
